// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg -- shared definitions for the UART receive frame timer.
//   state_t     : frame timer FSM states (IDLE, RUN)
//   MIN_DATA    : smallest supported number of data bits
//   START_BITS  : start bits per frame
//   frame_bits(): total bits in a frame, including the clamp of the
//                 data-bit count to MIN_DATA..data_max
package uart_rx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int unsigned MIN_DATA   = 5;
  localparam int unsigned START_BITS = 1;

  function automatic int unsigned frame_bits(input logic [3:0] data,
                                             input logic       parity,
                                             input logic       stop2,
                                             input int unsigned data_max);
    int unsigned d;
    d = 32'(data);
    if (d < MIN_DATA) d = MIN_DATA;
    if (d > data_max) d = data_max;
    return START_BITS + d + (parity ? 1 : 0) + (stop2 ? 2 : 1);
  endfunction

endpackage

// File: rtl/uart_rx_frame_timer_if.sv
// uart_rx_frame_timer_if -- signal bundle between the receiver control
// (master) and the frame timer (slave).
//   master drives : sample_en, hold, start, abort, rx_in,
//                   cfg_data_bits, cfg_parity, cfg_stop2
//   slave drives  : busy, sample_cnt, bit_idx, mid_strobe, bit_end,
//                   frame_done, false_start
interface uart_rx_frame_timer_if #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_MAX   = 8
);
  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_MAX + 4);

  logic             sample_en;
  logic             hold;
  logic             start;
  logic             abort;
  logic             rx_in;
  logic [3:0]       cfg_data_bits;
  logic             cfg_parity;
  logic             cfg_stop2;

  logic             busy;
  logic [CNT_W-1:0] sample_cnt;
  logic [BIT_W-1:0] bit_idx;
  logic             mid_strobe;
  logic             bit_end;
  logic             frame_done;
  logic             false_start;

  modport master (
    output sample_en, hold, start, abort, rx_in,
           cfg_data_bits, cfg_parity, cfg_stop2,
    input  busy, sample_cnt, bit_idx, mid_strobe, bit_end,
           frame_done, false_start
  );

  modport slave (
    input  sample_en, hold, start, abort, rx_in,
           cfg_data_bits, cfg_parity, cfg_stop2,
    output busy, sample_cnt, bit_idx, mid_strobe, bit_end,
           frame_done, false_start
  );

endinterface

// File: rtl/uart_sample_div.sv
// uart_sample_div -- modulo-OVERSAMPLE sample counter for one bit period.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : force the count back to 0 (priority over tick)
//   tick       : advance the count by one
//   cnt        : current sample index within the bit
//   wrap       : tick arriving on the last sample of the bit
//   mid        : tick arriving on the sample just before the bit centre
module uart_sample_div #(
  parameter int OVERSAMPLE = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clr,
  input  logic                          tick,
  output logic [$clog2(OVERSAMPLE)-1:0] cnt,
  output logic                          wrap,
  output logic                          mid
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] MID  = CNT_W'(OVERSAMPLE / 2 - 1);

  // OVERSAMPLE is a power of two, so the natural binary rollover is the
  // modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      cnt <= '0;
    else if (clr)   cnt <= '0;
    else if (tick)  cnt <= cnt + 1'b1;
  end

  assign wrap = tick && (cnt == LAST);
  assign mid  = tick && (cnt == MID);

endmodule

// File: rtl/uart_rx_frame_timer.sv
// uart_rx_frame_timer -- sample/bit timing engine for the UART receiver.
// Counts oversampling ticks over a whole frame and emits registered
// mid-bit strobes, bit-end strobes and a frame-complete pulse.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : uart_rx_frame_timer_if.slave (control in, strobes out)
// Build option:
//   START_VALIDATE_EN : when defined, rx_in is sampled at the start-bit
//                       centre and a high line rejects the frame with a
//                       false_start pulse. When undefined rx_in is ignored
//                       and false_start stays 0.
module uart_rx_frame_timer
  import uart_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_MAX   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  uart_rx_frame_timer_if.slave  bus
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_MAX + 4);
  // Last bit index of the 8N1 format the timer powers up with.
  localparam logic [BIT_W-1:0] RESET_LAST = BIT_W'(frame_bits(4'd8, 1'b0, 1'b0, DATA_MAX) - 1);

  state_t           state_q, state_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic [BIT_W-1:0] last_idx_q, last_idx_d;
  logic             mid_p1, mid_d;
  logic             end_p1, end_d;
  logic             done_p1, done_d;
  logic             fs_p1, fs_d;
  logic             fs_hit;

  logic             div_clr;
  logic             div_tick;
  logic [CNT_W-1:0] div_cnt;
  logic             div_wrap;
  logic             div_mid;

  assign div_tick = (state_q == RUN) && bus.sample_en && !bus.hold;

  uart_sample_div #(
    .OVERSAMPLE (OVERSAMPLE)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .clr   (div_clr),
    .tick  (div_tick),
    .cnt   (div_cnt),
    .wrap  (div_wrap),
    .mid   (div_mid)
  );

`ifndef START_VALIDATE_EN
  logic unused_rx_in;
  assign unused_rx_in = bus.rx_in;
`endif

  always_comb begin
    state_d    = state_q;
    bit_idx_d  = bit_idx_q;
    last_idx_d = last_idx_q;
    div_clr    = 1'b0;
    mid_d      = 1'b0;
    end_d      = 1'b0;
    done_d     = 1'b0;
    fs_d       = 1'b0;
    fs_hit     = 1'b0;
`ifdef START_VALIDATE_EN
    // A line still high at the start-bit centre was a glitch, not a start.
    fs_hit = div_mid && (bit_idx_q == '0) && bus.rx_in;
`endif

    if (bus.abort) begin
      // abort outranks start, hold and the frame-end tick; strobes stay 0.
      state_d   = IDLE;
      bit_idx_d = '0;
      div_clr   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          div_clr   = 1'b1;
          bit_idx_d = '0;
          if (bus.start) begin
            state_d    = RUN;
            last_idx_d = BIT_W'(frame_bits(bus.cfg_data_bits, bus.cfg_parity,
                                           bus.cfg_stop2, DATA_MAX) - 1);
          end
        end
        RUN: begin
          if (fs_hit) begin
            fs_d      = 1'b1;
            state_d   = IDLE;
            bit_idx_d = '0;
            div_clr   = 1'b1;
          end else begin
            mid_d = div_mid;
            if (div_wrap) begin
              end_d = 1'b1;
              if (bit_idx_q == last_idx_q) begin
                done_d    = 1'b1;
                state_d   = IDLE;
                bit_idx_d = '0;
                div_clr   = 1'b1;
              end else begin
                bit_idx_d = bit_idx_q + 1'b1;
              end
            end
          end
        end
        default: begin
          state_d   = IDLE;
          bit_idx_d = '0;
          div_clr   = 1'b1;
        end
      endcase
    end
  end

  // Stage p1: state, bit counter and one-clock strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      bit_idx_q  <= '0;
      last_idx_q <= RESET_LAST;
      mid_p1     <= 1'b0;
      end_p1     <= 1'b0;
      done_p1    <= 1'b0;
      fs_p1      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_idx_q  <= bit_idx_d;
      last_idx_q <= last_idx_d;
      mid_p1     <= mid_d;
      end_p1     <= end_d;
      done_p1    <= done_d;
      fs_p1      <= fs_d;
    end
  end

  assign bus.busy        = (state_q == RUN);
  assign bus.sample_cnt  = div_cnt;
  assign bus.bit_idx     = bit_idx_q;
  assign bus.mid_strobe  = mid_p1;
  assign bus.bit_end     = end_p1;
  assign bus.frame_done  = done_p1;
  assign bus.false_start = fs_p1;

endmodule

// File: tb/tb_uart_rx_frame_timer.sv
// tb_uart_rx_frame_timer -- randomized bench for uart_rx_frame_timer.
// The reference model counts effective ticks since the frame start and
// derives every expected output from that count and the frame length.
module tb_uart_rx_frame_timer;

  localparam int OS = 16;
  localparam int DM = 8;
`ifdef START_VALIDATE_EN
  localparam bit VALIDATE = 1'b1;
`else
  localparam bit VALIDATE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  uart_rx_frame_timer_if #(.OVERSAMPLE(OS), .DATA_MAX(DM)) bus ();

  uart_rx_frame_timer #(.OVERSAMPLE(OS), .DATA_MAX(DM)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  bit m_run = 1'b0;
  int m_k   = 0;
  int m_len = 0;
  bit e_mid, e_end, e_done, e_fs;

  // per-frame observations
  int ticks, mids, ends;
  bit done_seen, fs_seen;

  function automatic int fb(input int d, input bit p, input bit s);
    if (d < 5)  d = 5;
    if (d > DM) d = DM;
    return 1 + d + (p ? 1 : 0) + (s ? 2 : 1);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("busy",        int'(bus.busy),        int'(m_run));
    check("sample_cnt",  int'(bus.sample_cnt),  m_k % OS);
    check("bit_idx",     int'(bus.bit_idx),     m_k / OS);
    check("mid_strobe",  int'(bus.mid_strobe),  int'(e_mid));
    check("bit_end",     int'(bus.bit_end),     int'(e_end));
    check("frame_done",  int'(bus.frame_done),  int'(e_done));
    check("false_start", int'(bus.false_start), int'(e_fs));
  endtask

  // One clock: drive inputs, advance model, compare every output.
  task automatic step(input bit se, input bit hd, input bit st, input bit ab);
    int d;
    bit p, s, rx;
    bus.sample_en = se;
    bus.hold      = hd;
    bus.start     = st;
    bus.abort     = ab;
    d  = int'(bus.cfg_data_bits);
    p  = bus.cfg_parity;
    s  = bus.cfg_stop2;
    rx = bus.rx_in;
    @(posedge clk);
    #1;
    e_mid = 1'b0; e_end = 1'b0; e_done = 1'b0; e_fs = 1'b0;
    if (ab) begin
      m_run = 1'b0;
      m_k   = 0;
    end else if (!m_run) begin
      if (st) begin
        m_run = 1'b1;
        m_k   = 0;
        m_len = fb(d, p, s) * OS;
      end
    end else if (se && !hd) begin
      m_k++;
      ticks++;
      if (VALIDATE && m_k == OS / 2 && rx) begin
        e_fs  = 1'b1;
        m_run = 1'b0;
        m_k   = 0;
      end else begin
        e_mid = (m_k % OS == OS / 2);
        e_end = (m_k % OS == 0);
        if (m_k == m_len) begin
          e_done = 1'b1;
          m_run  = 1'b0;
          m_k    = 0;
        end
      end
    end
    compare_all();
    if (bus.mid_strobe)  mids++;
    if (bus.bit_end)     ends++;
    if (bus.frame_done)  done_seen = 1'b1;
    if (bus.false_start) fs_seen = 1'b1;
  endtask

  task automatic begin_frame(input int d, input bit p, input bit s, input bit rx);
    bus.cfg_data_bits = d[3:0];
    bus.cfg_parity    = p;
    bus.cfg_stop2     = s;
    bus.rx_in         = rx;
    ticks = 0; mids = 0; ends = 0;
    done_seen = 1'b0; fs_seen = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Full frame with random tick gaps; noisy adds hold, stray starts and
  // config churn while the frame runs.
  task automatic run_frame(input string tag, input int d, input bit p, input bit s,
                           input bit rx, input bit noisy);
    int exp_ticks;
    exp_ticks = fb(d, p, s) * OS;
    begin_frame(d, p, s, rx);
    for (int c = 0; c < 4000 && !done_seen; c++) begin
      if (noisy) begin
        bus.cfg_data_bits = 4'($urandom_range(0, 15));
        bus.cfg_parity    = 1'($urandom);
        bus.cfg_stop2     = 1'($urandom);
      end
      step($urandom_range(0, 3) != 0,
           noisy && ($urandom_range(0, 7) == 0),
           noisy && ($urandom_range(0, 15) == 0),
           1'b0);
    end
    check({tag, "_done"},  int'(done_seen), 1);
    check({tag, "_ticks"}, ticks, exp_ticks);
    check({tag, "_mids"},  mids, exp_ticks / OS);
    check({tag, "_ends"},  ends, exp_ticks / OS);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.sample_en = 1'b0; bus.hold = 1'b0; bus.start = 1'b0; bus.abort = 1'b0;
    bus.rx_in = 1'b0;
    bus.cfg_data_bits = 4'd8; bus.cfg_parity = 1'b0; bus.cfg_stop2 = 1'b0;
    e_mid = 1'b0; e_end = 1'b0; e_done = 1'b0; e_fs = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // 8N1 clean, then back-to-back 7E2 with no idle gap
    run_frame("8n1", 8, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("7e2", 7, 1'b1, 1'b1, 1'b0, 1'b0);
    // clamping
    run_frame("clamp_hi", 12, 1'b0, 1'b0, 1'b0, 1'b0);
    run_frame("clamp_lo", 2,  1'b0, 1'b0, 1'b0, 1'b0);

    // hold freezes counters while sample_en keeps pulsing
    begin_frame(8, 1'b0, 1'b0, 1'b0);
    repeat (40) step(1'b1, 1'b0, 1'b0, 1'b0);
    repeat (20) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("hold_cnt", int'(bus.sample_cnt), 8);
    check("hold_bit", int'(bus.bit_idx), 2);
    for (int c = 0; c < 400 && !done_seen; c++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("hold_ticks", ticks, 160);

    // abort together with start at tick 70
    begin_frame(8, 1'b0, 1'b0, 1'b0);
    repeat (70) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 1'b1);
    check("abort_busy", int'(bus.busy), 0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("abort_no_done", int'(done_seen), 0);
    run_frame("after_abort", 8, 1'b0, 1'b0, 1'b0, 1'b0);

    // asynchronous reset at tick 50
    begin_frame(8, 1'b0, 1'b0, 1'b0);
    repeat (50) step(1'b1, 1'b0, 1'b0, 1'b0);
    bus.sample_en = 1'b0; bus.start = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_run = 1'b0; m_k = 0;
    e_mid = 1'b0; e_end = 1'b0; e_done = 1'b0; e_fs = 1'b0;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    compare_all();
    run_frame("after_reset", 6, 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef START_VALIDATE_EN
    // high line at the start-bit centre rejects the frame
    begin_frame(8, 1'b0, 1'b0, 1'b1);
    for (int c = 0; c < 200 && !fs_seen; c++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check("fs_seen", int'(fs_seen), 1);
    check("fs_ticks", ticks, OS / 2);
    check("fs_mids", mids, 0);
    check("fs_busy", int'(bus.busy), 0);
    run_frame("valid_start", 8, 1'b0, 1'b0, 1'b0, 1'b0);
`else
    // rx_in is ignored without start validation
    run_frame("rx_ignored", 8, 1'b0, 1'b0, 1'b1, 1'b0);
`endif

    // randomized formats with hold, stray starts and config churn
    for (int i = 0; i < 6; i++) begin
      run_frame("rand", int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom),
                1'b0, 1'b1);
    end

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame_timer.md
Name: uart_rx_frame_timer

Overview:
Parametrised sample/bit timing engine for the UART receiver. It counts oversampling ticks across a whole frame and generates mid-bit sampling strobes, bit-boundary strobes and a frame-complete pulse. The frame format is configurable at run time: 5..DATA_MAX data bits, optional parity, 1 or 2 stop bits. It sits between the baud-rate sample-enable generator and the receiver shift register/FSM.

Parameters:
OVERSAMPLE, 16, samples per bit; power of two, >= 4
DATA_MAX, 8, maximum data bits per frame; range 5..9

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
sample_en  input  1  one-clk oversampling tick from the baud generator
hold  input  1  freeze: sample_en is ignored while high
start  input  1  begin a frame (start-bit edge detected upstream)
abort  input  1  cancel the current frame
rx_in  input  1  synchronised serial line; used only with START_VALIDATE_EN
cfg_data_bits  input  4  data bits per frame, latched at start
cfg_parity  input  1  1 = parity bit present, latched at start
cfg_stop2  input  1  1 = two stop bits, latched at start
busy  output  1  frame in progress
sample_cnt  output  $clog2(OVERSAMPLE)  sample index within the current bit
bit_idx  output  $clog2(DATA_MAX+4)  current bit index (0 = start bit)
mid_strobe  output  1  one-clk pulse at the mid-point of each bit
bit_end  output  1  one-clk pulse at the end of each bit
frame_done  output  1  one-clk pulse when the frame completes
false_start  output  1  one-clk pulse when a start bit is rejected

Behaviour:
- Reset: state IDLE; all outputs and counters 0; latched config = 8N1.
- FSM states: IDLE, RUN.
- IDLE:
  - start=1 and abort=0 -> RUN next clk.
  - Latch config; sample_cnt=0, bit_idx=0, busy=1.
- Config rules:
  - cfg_data_bits < 5 is treated as 5; > DATA_MAX is treated as DATA_MAX.
  - FRAME_BITS = 1 + data + parity + (stop2 ? 2 : 1).
  - Config changes during RUN have no effect.
- RUN, on an effective tick (sample_en=1 and hold=0):
  - sample_cnt increments modulo OVERSAMPLE.
  - On wrap (sample_cnt==OVERSAMPLE-1), bit_idx increments.
- No effective tick: counters hold their values.
- Strobes (all registered, latency 1 clk after the qualifying tick):
  - mid_strobe on the tick where sample_cnt == OVERSAMPLE/2-1.
  - bit_end on the tick where sample_cnt == OVERSAMPLE-1.
- Frame end: on the tick with sample_cnt==OVERSAMPLE-1 and bit_idx==FRAME_BITS-1:
  - Next clk: bit_end=1, frame_done=1, busy=0, state IDLE, counters 0.
  - Total = FRAME_BITS*OVERSAMPLE effective ticks per frame.
- start while in RUN is ignored.
- A start arriving in the same clk that frame_done is asserted is accepted; this gives back-to-back frames.
- abort in any state:
  - Next clk: IDLE, counters 0, busy=0.
  - No frame_done; any pending strobes are suppressed.
  - abort beats start, hold and frame end in the same clk.
- reset mid-frame: immediate return to the reset values.

Optional Feature:
START_VALIDATE_EN
- Defined: at the start-bit mid-point (bit_idx==0, mid tick), rx_in is checked.
  - rx_in=1 -> next clk: false_start=1, IDLE, counters 0, no mid_strobe for that tick.
  - rx_in=0 -> normal operation.
- Undefined: rx_in is ignored and false_start is tied to 0.

Decomposition:
- Shared package uart_rx_pkg holds:
  - State enum (IDLE, RUN).
  - Frame-format constants: MIN_DATA=5, START_BITS=1.
  - Function frame_bits(data, parity, stop2) including the clamp.
- One natural sub-module: uart_sample_div, the modulo-OVERSAMPLE tick counter with wrap/mid flags.
- bit_idx and the FSM stay in the top module.

Test Plan:
- 8N1, OVERSAMPLE=16: start, then 160 sample_en pulses -> 10 mid_strobes; frame_done 1 clk after tick 160; busy low thereafter.
- 7E2 (cfg_data_bits=7, parity=1, stop2=1) -> frame_done after tick 176; 11 mid_strobes and 11 bit_ends.
- cfg_data_bits=12 with DATA_MAX=8 -> clamped to 8N1: frame_done after tick 160. cfg_data_bits=2 -> 5N1: done after tick 112.
- hold=1 for 20 clks at tick 40 with sample_en still pulsing -> sample_cnt/bit_idx frozen (8/2); frame_done still at effective tick 160.
- abort at tick 70 together with start -> IDLE, busy=0, no frame_done. A new start then yields a full 160-tick frame. Reset at tick 50 -> all outputs 0.
- START_VALIDATE_EN defined, rx_in=1 at tick 8 -> false_start pulse, busy=0, 0 mid_strobes. With rx_in=0 -> normal frame.
